// File: rtl/digest_pager_pkg.sv
// Shared types and helpers for the digest pager.
// Optional feature macro: DIGEST_PAGER_HOLD_EN (adds the `hold` input to digest_pager).
package digest_pager_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_STEP   = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_RSVD   = 2'b11
    } pager_mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHOW  = 1'b1
    } pager_state_e;

    // Counter/index width for n distinct values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pager_debounce.sv
// Step button conditioner: 2-FF synchroniser, then a level filter that only
// accepts a new level after DEB_TICKS consecutive scan ticks disagreeing with
// the current one. Emits a one-clock pulse on each accepted 0->1 change.
module pager_debounce
    import digest_pager_pkg::*;
#(
    parameter int DEB_TICKS = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CNT_W = clog2_min1(DEB_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronise the raw button and filter it on scan ticks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (tick_i) begin
                if (sync2_q == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    rise_q  <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/digest_pager.sv
// Digest pager: holds a captured hash digest and presents one SLICE_W-bit
// page at a time (manual / debounced step / timed auto-scroll), and produces
// the display scan tick.
// Optional feature macro: DIGEST_PAGER_HOLD_EN adds input `hold`, which
// suppresses step/auto advances and freezes the scroll counter.
module digest_pager
    import digest_pager_pkg::*;
#(
    parameter  int DIGEST_W     = 512,
    parameter  int SLICE_W      = 16,
    parameter  int TICK_DIV     = 100000,
    parameter  int SCROLL_TICKS = 5000,
    parameter  int DEB_TICKS    = 8,
    localparam int NUM_SLICES   = DIGEST_W / SLICE_W,
    localparam int IDX_W        = clog2_min1(NUM_SLICES)
) (
    input  logic                sysclk_125mhz,
    input  logic                rst,
    input  logic [DIGEST_W-1:0] digest,
    input  logic                digest_valid,
    input  logic [1:0]          mode,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic                step_btn,
`ifdef DIGEST_PAGER_HOLD_EN
    input  logic                hold,
`endif
    output logic [SLICE_W-1:0]  slice_out,
    output logic [IDX_W-1:0]    slice_idx,
    output logic                loaded,
    output logic                wrap_pulse,
    output logic                scan_tick
);

    localparam int TICK_W = clog2_min1(TICK_DIV);
    localparam int SCR_W  = clog2_min1(SCROLL_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCR_W-1:0]  SCR_LAST  = SCR_W'(SCROLL_TICKS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SLICES - 1);

    pager_state_e        state_q;
    pager_mode_e         mode_q;
    pager_mode_e         mode_e;
    logic [DIGEST_W-1:0] shadow_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wrap_pend_q, wrap_d;
    logic [SLICE_W-1:0]  slice_out_q;
    logic [IDX_W-1:0]    slice_idx_q;
    logic                wrap_pulse_q;
    logic                loaded_q;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SCR_W-1:0]    scroll_cnt_q, scroll_cnt_d;
    logic                auto_adv;
    logic                advance;
    logic                step_rise;
    logic                adv_en;

`ifdef DIGEST_PAGER_HOLD_EN
    assign adv_en = ~hold;
`else
    assign adv_en = 1'b1;
`endif

    assign mode_e    = pager_mode_e'(mode);
    assign scan_tick = (tick_cnt_q == TICK_LAST);

    pager_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_deb (
        .clk_i  (sysclk_125mhz),
        .rst_i  (rst),
        .tick_i (scan_tick),
        .btn_i  (step_btn),
        .rise_o (step_rise)
    );

    // Next-state for the free-running tick divider and the auto-scroll counter.
    always_comb begin
        tick_cnt_d   = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
        scroll_cnt_d = scroll_cnt_q;
        auto_adv     = 1'b0;
        if (mode_e != mode_q) begin
            scroll_cnt_d = '0;
        end else if (state_q == ST_SHOW && mode_e == MODE_AUTO && adv_en && scan_tick) begin
            if (scroll_cnt_q == SCR_LAST) begin
                scroll_cnt_d = '0;
                auto_adv     = 1'b1;
            end else begin
                scroll_cnt_d = scroll_cnt_q + SCR_W'(1);
            end
        end
    end

    // Next index: capture forces 0 and beats any advance; wrap flagged only on advance.
    always_comb begin
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        advance = 1'b0;
        if (digest_valid) begin
            idx_d = '0;
        end else if (state_q == ST_SHOW) begin
            case (mode_e)
                MODE_STEP: advance = step_rise & adv_en;
                MODE_AUTO: advance = auto_adv;
                default:   idx_d   = (int'(sel_idx) >= NUM_SLICES) ? LAST_IDX : sel_idx;
            endcase
            if (advance) begin
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    // Tick divider and scroll counter registers.
    always_ff @(posedge sysclk_125mhz or posedge rst) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            scroll_cnt_q <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            scroll_cnt_q <= scroll_cnt_d;
        end
    end

    // Pager FSM: capture, index, and the output stage that lags the index by one edge.
    always_ff @(posedge sysclk_125mhz or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            loaded_q     <= 1'b0;
            mode_q       <= MODE_MANUAL;
            shadow_q     <= '0;
            idx_q        <= '0;
            wrap_pend_q  <= 1'b0;
            slice_out_q  <= '0;
            slice_idx_q  <= '0;
            wrap_pulse_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (digest_valid) begin
                        state_q  <= ST_SHOW;
                        loaded_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (digest_valid) begin
                shadow_q <= digest;
            end
            mode_q       <= mode_e;
            idx_q        <= idx_d;
            wrap_pend_q  <= wrap_d;
            slice_out_q  <= shadow_q[int'(idx_q) * SLICE_W +: SLICE_W];
            slice_idx_q  <= idx_q;
            wrap_pulse_q <= wrap_pend_q;
        end
    end

    assign slice_out  = slice_out_q;
    assign slice_idx  = slice_idx_q;
    assign loaded     = loaded_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_digest_pager.sv
// Bench for digest_pager with small timing parameters.
module tb_digest_pager;

    localparam int DW = 512;
    localparam int SW = 16;
    localparam int NS = DW / SW;
    localparam int IW = 5;
    localparam int TD = 4;
    localparam int ST = 2;
    localparam int DT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] digest;
    logic          digest_valid;
    logic [1:0]    mode;
    logic [IW-1:0] sel_idx;
    logic          step_btn;
`ifdef DIGEST_PAGER_HOLD_EN
    logic          hold;
`endif
    logic [SW-1:0] slice_out;
    logic [IW-1:0] slice_idx;
    logic          loaded;
    logic          wrap_pulse;
    logic          scan_tick;

    digest_pager #(
        .DIGEST_W     (DW),
        .SLICE_W      (SW),
        .TICK_DIV     (TD),
        .SCROLL_TICKS (ST),
        .DEB_TICKS    (DT)
    ) dut (
        .sysclk_125mhz (clk),
        .rst           (rst),
        .digest        (digest),
        .digest_valid  (digest_valid),
        .mode          (mode),
        .sel_idx       (sel_idx),
        .step_btn      (step_btn),
`ifdef DIGEST_PAGER_HOLD_EN
        .hold          (hold),
`endif
        .slice_out     (slice_out),
        .slice_idx     (slice_idx),
        .loaded        (loaded),
        .wrap_pulse    (wrap_pulse),
        .scan_tick     (scan_tick)
    );

    // clock / reset-relative cycle count
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int wrap_seen = 0;
    always @(negedge clk) begin
        if (wrap_pulse === 1'b1) wrap_seen++;
    end

    // reference model: the captured digest as an array of slices
    logic [SW-1:0] model [NS];
    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_digest(input bit seq);
        for (int i = 0; i < NS; i++) begin
            model[i] = seq ? SW'(16'h1000 + i) : SW'($urandom);
            digest[i*SW +: SW] = model[i];
        end
        digest_valid = 1'b1;
        step(1);
        digest_valid = 1'b0;
    endtask

    task automatic set_manual(input int idx);
        mode    = 2'b00;
        sel_idx = IW'(idx);
        step(2);
    endtask

    task automatic wait_phase0();
        for (int k = 0; k < 2 * TD; k++) begin
            if (cyc % TD == 0) break;
            step(1);
        end
    endtask

    task automatic press(input int hi_clks, input int lo_clks);
        step_btn = 1'b1;
        step(hi_clks);
        step_btn = 1'b0;
        step(lo_clks);
    endtask

    // Auto mode from start_idx: index must advance by one every TD*ST clocks,
    // data tracks the index, and wrap_pulse marks only the 31->0 step.
    task automatic run_auto(input int ncyc, input int start_idx, input int first_lo,
                            input int first_hi, output int changes);
        int prev;
        int last_chg;
        int nxt;
        prev = start_idx;
        last_chg = -1;
        changes = 0;
        for (int c = 0; c < ncyc; c++) begin
            step(1);
            if (int'(slice_idx) != prev) begin
                nxt = (prev + 1) % NS;
                check("auto_next", 64'(slice_idx), 64'(nxt));
                check("auto_data", 64'(slice_out), 64'(model[nxt]));
                check("auto_wrap", 64'(wrap_pulse), 64'(nxt == 0));
                if (last_chg >= 0) check("auto_gap", 64'(c - last_chg), 64'(TD * ST));
                else check("auto_first_lat", 64'(c >= first_lo && c <= first_hi), 64'(1));
                last_chg = c;
                prev = nxt;
                changes++;
            end
        end
    endtask

    initial begin
        int w0;
        int n;
        int exp_idx;
        int changes;
        int errs;
        rst = 1'b1;
        digest = '0;
        digest_valid = 1'b0;
        mode = 2'b00;
        sel_idx = 5'd5;
        step_btn = 1'b0;
`ifdef DIGEST_PAGER_HOLD_EN
        hold = 1'b0;
`endif
        #23;
        // 1: reset state, scan tick cadence, nothing shown before capture
        check("rst_slice_out", 64'(slice_out), 64'(0));
        check("rst_loaded", 64'(loaded), 64'(0));
        check("rst_scan_tick", 64'(scan_tick), 64'(0));
        rst = 1'b0;
        step(1);
        errs = 0;
        for (int c = 0; c < 16; c++) begin
            if (scan_tick !== (cyc % TD == TD - 1)) errs++;
            if (slice_out !== '0 || loaded !== 1'b0 || slice_idx !== '0) errs++;
            step(1);
        end
        check("scan_tick_and_empty", 64'(errs), 64'(0));

        // 2: capture then manual selection
        w0 = wrap_seen;
        load_digest(1'b1);
        step(2);
        check("man5_slice", 64'(slice_out), 64'(16'h1005));
        check("man5_idx", 64'(slice_idx), 64'(5));
        check("loaded", 64'(loaded), 64'(1));
        set_manual(31);
        check("man31_slice", 64'(slice_out), 64'(16'h101F));
        set_manual(0);
        check("man0_slice", 64'(slice_out), 64'(16'h1000));
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, NS - 1);
            mode = (k % 2 == 0) ? 2'b00 : 2'b11;
            sel_idx = IW'(n);
            step(2);
            check("man_rand_idx", 64'(slice_idx), 64'(n));
            check("man_rand_slice", 64'(slice_out), 64'(model[n]));
        end
        check("man_no_wrap", 64'(wrap_seen - w0), 64'(0));

        // 3: auto scroll across the wrap
        set_manual(30);
        w0 = wrap_seen;
        mode = 2'b10;
        run_auto(44, 30, 6, 9, changes);
        check("auto_changes", 64'(changes >= 4), 64'(1));
        check("auto_wrap_count", 64'(wrap_seen - w0), 64'(1));

        // 4: step mode - glitches ignored, clean presses advance by one each
        set_manual(10);
        mode = 2'b01;
        step(4);
        for (int k = 0; k < 3; k++) begin
            press($urandom_range(1, DT - 1) * TD, 4 * TD);
            check("step_glitch", 64'(slice_idx), 64'(10));
        end
        n = $urandom_range(2, 4);
        for (int k = 0; k < n; k++) press($urandom_range(DT + 1, 7) * TD, (DT + 2) * TD);
        step(4);
        exp_idx = (10 + n) % NS;
        check("step_count_idx", 64'(slice_idx), 64'(exp_idx));
        check("step_count_slice", 64'(slice_out), 64'(model[exp_idx]));
        step(5 * TD);
        check("step_release_none", 64'(slice_idx), 64'(exp_idx));
        set_manual(30);
        w0 = wrap_seen;
        mode = 2'b01;
        step(2);
        press(6 * TD, (DT + 2) * TD);
        press(6 * TD, (DT + 2) * TD);
        check("step_wrap_idx", 64'(slice_idx), 64'(0));
        check("step_wrap_slice", 64'(slice_out), 64'(model[0]));
        check("step_wrap_pulse", 64'(wrap_seen - w0), 64'(1));

        // 5: capture on the same edge as a debounced step advance
        set_manual(7);
        mode = 2'b01;
        step(2);
        w0 = wrap_seen;
        wait_phase0();
        step_btn = 1'b1;
        step(DT * TD);
        load_digest(1'b0);
        step(1);
        check("coinc_idx", 64'(slice_idx), 64'(0));
        check("coinc_slice", 64'(slice_out), 64'(model[0]));
        step(8 * TD);
        check("coinc_advance_lost", 64'(slice_idx), 64'(0));
        step_btn = 1'b0;
        step(5 * TD);
        check("coinc_release", 64'(slice_idx), 64'(0));
        check("coinc_no_wrap", 64'(wrap_seen - w0), 64'(0));

        // 6: asynchronous reset in the middle of auto scrolling
        mode = 2'b10;
        step(13);
        #2;
        rst = 1'b1;
        #1;
        check("arst_slice_out", 64'(slice_out), 64'(0));
        check("arst_slice_idx", 64'(slice_idx), 64'(0));
        check("arst_loaded", 64'(loaded), 64'(0));
        check("arst_wrap", 64'(wrap_pulse), 64'(0));
        check("arst_scan_tick", 64'(scan_tick), 64'(0));
        #3;
        rst = 1'b0;
        step(1);
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            if (loaded !== 1'b0 || slice_out !== '0 || slice_idx !== '0) errs++;
            step(1);
        end
        check("arst_stays_empty", 64'(errs), 64'(0));
        load_digest(1'b0);
        step(2);
        check("arst_reload", 64'(loaded), 64'(1));
        check("arst_reload_slice", 64'(slice_out), 64'(model[0]));

`ifdef DIGEST_PAGER_HOLD_EN
        // 7: hold freezes auto advance
        set_manual(3);
        hold = 1'b1;
        mode = 2'b10;
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (slice_idx !== IW'(3)) errs++;
        end
        check("hold_frozen", 64'(errs), 64'(0));
        hold = 1'b0;
        run_auto(20, 3, 5, 9, changes);
        check("hold_resume", 64'(changes >= 1), 64'(1));
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

endmodule
